button_debounce_pulse: RTL and testbench



---
 rtl/btn_pkg.sv | 18 +
 rtl/sync_2ff.sv | 23 ++
 rtl/button_debounce_pulse.sv | 137 +++++++++++++
 tb/tb_button_debounce_pulse.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for pushbutton front ends.
package btn_pkg;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned DEBOUNCE_MS = 10;
    localparam int unsigned HOLD_MS     = 1000;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned HOLD_CYCLES_DEF     = (CLK_HZ / 1000) * HOLD_MS;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous pad inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_debounce_pulse.sv
// Synchronises and debounces a pushbutton, emitting a clean level and press/release pulses.
// Optional long-press detection is enabled by defining LONG_PRESS_EN.
module button_debounce_pulse
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (HOLD_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_hold
        $error("HOLD_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    logic             s2;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_d, release_d, level_d;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (button),
        .q     (s2)
    );

    // Stable-time FSM: a WAIT state only commits once s2 has held for the full window.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s2) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s2) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            btn_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

`ifdef LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              fired_q, fired_d, long_d;

    // Hold timer survives rejected releases; fired flag blocks repeats until a new press.
    always_comb begin
        hold_d  = hold_q;
        fired_d = fired_q;
        long_d  = 1'b0;
        if (state_q == PRESS_WAIT && state_d == PRESSED) begin
            hold_d  = '0;
            fired_d = 1'b0;
        end else if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
            if (hold_q == HOLD_LAST) begin
                if (!fired_q) begin
                    long_d  = 1'b1;
                    fired_d = 1'b1;
                end
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            fired_q    <= 1'b0;
            long_press <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            fired_q    <= fired_d;
            long_press <= long_d;
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Self-checking bench for button_debounce_pulse (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16).
module tb_button_debounce_pulse;

    localparam int D = 4;
    localparam int H = 16;
    localparam int NVEC = 28;

    logic clk;
    logic rst_n;
    logic button;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    int n_cmp = 0;
    int n_err = 0;

    button_debounce_pulse #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .button        (button),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the level flips once s2 has disagreed with it for D+1 consecutive edges.
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0;
    logic m_press = 1'b0, m_release = 1'b0, m_long = 1'b0, m_fired = 1'b0;
    int   m_run = 0, m_age = 0;

    task automatic model_step();
        logic s2_old, held_before;
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_age = 0;
            m_press = 0; m_release = 0; m_long = 0; m_fired = 0;
            return;
        end
        s2_old      = m_s2;
        held_before = m_level;
        m_s2        = m_s1;
        m_s1        = button;
        m_press     = 0;
        m_release   = 0;
        m_long      = 0;
        if (s2_old != m_level) begin
            m_run++;
            if (m_run == D + 1) begin
                m_level = !m_level;
                m_run   = 0;
                if (m_level) m_press = 1; else m_release = 1;
            end
        end else begin
            m_run = 0;
        end
`ifdef LONG_PRESS_EN
        if (m_press) begin
            m_age   = 0;
            m_fired = 0;
        end else if (held_before) begin
            if (m_age < H) m_age++;
            if (m_age == H && !m_fired) begin
                m_long  = 1;
                m_fired = 1;
            end
        end
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [3:0] dut_vec();
        return {btn_level, press_pulse, release_pulse, long_press};
    endfunction

    function automatic logic [3:0] model_vec();
        return {m_level, m_press, m_release, m_long};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got lvl/prs/rel/long=%b want %b @%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d @%0t", name, act, exp, $time);
        end
    endtask

    // Run n edges with fixed inputs, recording pulse counts and the edge offset of the first of each.
    task automatic watch(input int n, output int np, output int fp, output int nr,
                         output int fr, output int nl, output int fl);
        np = 0; nr = 0; nl = 0; fp = -1; fr = -1; fl = -1;
        for (int k = 0; k < n; k++) begin
            tick();
            if (press_pulse)   begin np++; if (fp < 0) fp = k; end
            if (release_pulse) begin nr++; if (fr < 0) fr = k; end
            if (long_press)    begin nl++; if (fl < 0) fl = k; end
            if (press_pulse && release_pulse) check("pulse_overlap", dut_vec(), 4'b0);
        end
    endtask

    typedef struct {
        logic       btn;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [NVEC];

    initial begin
        int np, fp, nr, fr, nl, fl, len;

        // Clean press at row 0, release at row 10, 3-cycle glitch at rows 18..20.
        for (int i = 0; i < NVEC; i++) begin
            tbl[i].btn = (i < 10) || (i >= 18 && i <= 20);
            tbl[i].exp = 4'b0000;
        end
        for (int i = 6; i < 16; i++) tbl[i].exp[3] = 1'b1;
        tbl[6].exp[2]  = 1'b1;
        tbl[16].exp[1] = 1'b1;

        rst_n  = 1'b0;
        button = 1'b0;
        tick();
        tick();
        check("reset_state", dut_vec(), 4'b0000);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_after_reset", dut_vec(), 4'b0000);

        for (int i = 0; i < NVEC; i++) begin
            button = tbl[i].btn;
            tick();
            check($sformatf("vec[%0d]", i), dut_vec(), tbl[i].exp);
        end

        // Bounce 1,0,1,0 then hold high.
        button = 1; tick(); button = 0; tick();
        button = 1; tick(); button = 0; tick();
        button = 1;
        watch(14, np, fp, nr, fr, nl, fl);
        check_int("bounce_press_count", np, 1);
        check_int("bounce_press_offset", fp, 6);
        check_int("bounce_release_count", nr, 0);
        check("bounce_level", dut_vec(), 4'b1000);

        button = 0;
        watch(12, np, fp, nr, fr, nl, fl);
        check_int("release_count", nr, 1);
        check_int("release_offset", fr, 6);
        check_int("release_press_count", np, 0);
        check("release_level", dut_vec(), 4'b0000);

        // Reset in the middle of PRESS_WAIT, button held through reset release.
        button = 1;
        watch(5, np, fp, nr, fr, nl, fl);
        check_int("pre_reset_press_count", np, 0);
        rst_n = 0;
        #1;
        check("reset_async_clear", dut_vec(), 4'b0000);
        tick();
        tick();
        check("reset_held", dut_vec(), 4'b0000);
        rst_n = 1;
        watch(12, np, fp, nr, fr, nl, fl);
        check_int("post_reset_press_count", np, 1);
        check_int("post_reset_press_offset", fp, 6);

        button = 0;
        watch(12, np, fp, nr, fr, nl, fl);
        check_int("post_reset_release_count", nr, 1);

        // Long hold: press then 30+ cycles held.
        button = 1;
        watch(40, np, fp, nr, fr, nl, fl);
        check_int("hold_press_count", np, 1);
`ifdef LONG_PRESS_EN
        check_int("long_press_count", nl, 1);
        check_int("long_press_delay", fl - fp, 16);
`else
        check_int("long_press_count", nl, 0);
`endif
        button = 0;
        repeat (12) tick();

        // Randomised runs with occasional reset, checked every cycle against the model.
        for (int c = 0; c < 3000;) begin
            len    = int'($urandom_range(1, 12));
            button = 1'($urandom_range(0, 1));
            for (int k = 0; k < len && c < 3000; k++) begin
                rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
                tick();
                check("random", dut_vec(), model_vec());
                c++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
